// File: rtl/counter_mod_param.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : counter_mod_param
//  Description : Parametrised modulo-N up/down counter for the clock chain,
//                with synchronous clear, range-clamped load, an enable
//                prescaler and a combinational terminal-count carry so that
//                stages can be cascaded (carry -> enable of the next stage).
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module counter_mod_param #(
   parameter int WIDTH    = 6,
   parameter int MODULUS  = 60,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             carry,
   output logic             load_err
);

   // Highest legal count value; every compare is done at WIDTH bits.
   localparam logic [WIDTH-1:0] c_max_count = WIDTH'(MODULUS - 1);

   // Parameter sanity: an illegal modulus or prescale stops elaboration.
   generate
      if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
         $error("counter_mod_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("counter_mod_param: PRESCALE must be >= 1");
      end
   endgenerate

   logic             tick;
   logic [WIDTH-1:0] count_d, count_q;
   logic             load_err_d, load_err_q;
   logic             load_oor;
   logic             terminal;

   // Prescaler: divides enabled cycles down to count steps. With PRESCALE = 1
   // no register is needed and every enabled cycle is a step.
   generate
      if (PRESCALE > 1) begin : g_prescale
         localparam int c_pre_w = $clog2(PRESCALE);
         localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

         logic [c_pre_w-1:0] pre_d, pre_q;

         // Next prescaler value: restart on clear/load, advance while enabled.
         always_comb begin
            pre_d = pre_q;
            if (clear || load) begin
               pre_d = '0;
            end else if (enable) begin
               pre_d = (pre_q == c_pre_last) ? '0 : pre_q + c_pre_w'(1);
            end
         end

         // Prescaler register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pre_q <= '0;
            end else begin
               pre_q <= pre_d;
            end
         end

         assign tick = enable & (pre_q == c_pre_last);
      end else begin : g_no_prescale
         assign tick = enable;
      end
   endgenerate

   // data == MODULUS-1 is the largest value accepted unchanged.
   assign load_oor = (data > c_max_count);

   // Wrap point depends on the direction currently selected.
   assign terminal = up_down ? (count_q == c_max_count) : (count_q == '0);

   // Carry is combinational so the next stage steps on the same edge as the
   // wrap; clear and load suppress it because they pre-empt the step.
   assign carry = tick & ~clear & ~load & terminal;

   // Next count and load-error flag; priority clear > load > counting.
   always_comb begin
      count_d    = count_q;
      load_err_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         if (load_oor) begin
            count_d    = c_max_count;
            load_err_d = 1'b1;
         end else begin
            count_d = data;
         end
      end else if (tick) begin
         if (up_down) begin
            count_d = (count_q == c_max_count) ? '0 : count_q + WIDTH'(1);
         end else begin
            count_d = (count_q == '0) ? c_max_count : count_q - WIDTH'(1);
         end
      end
   end

   // Count and load-error registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign load_err = load_err_q;

endmodule
`default_nettype wire
